up0628_core: RTL and testbench

- Top-level wrapper for a tiny 8-bit accumulator microprocessor: the TinyTapeout user block tt_um_maxluppe_uP0628_24.
- Holds a 16x8 program RAM loaded serially through ui_in, a 4x8 register file, an accumulator A and Z/C flags.
- Executes one instruction per clock; drives an 8-bit output port and exposes PC and carry on the bidirectional pins.

---
 rtl/up0628_pkg.sv | 28 ++
 rtl/up0628_if.sv | 22 ++
 rtl/up0628_alu.sv | 71 +++++++
 rtl/up0628_core.sv | 122 ++++++++++++
 tb/tb_up0628_core.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/up0628_pkg.sv
// Shared constants for the up0628 accumulator micro:
// opcodes, bidir output-enable value and uio_in control-bit positions.
package up0628_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDH  = 4'h2;
    localparam logic [3:0] OP_MOVR = 4'h3;
    localparam logic [3:0] OP_MOVA = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_SH   = 4'hA;
    localparam logic [3:0] OP_IN   = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
    localparam logic [3:0] OP_JMP  = 4'hD;
    localparam logic [3:0] OP_JZ   = 4'hE;
    localparam logic [3:0] OP_JC   = 4'hF;

    localparam logic [7:0] UIO_OE_VAL = 8'hF8;

    localparam int LOAD_BIT = 0;
    localparam int HOLD_BIT = 1;
    localparam int VIEW_BIT = 2;

endpackage

// File: rtl/up0628_if.sv
// Pin bundle of the up0628 user block: enable, input,
// bidirectional and output ports seen by the harness.
interface up0628_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/up0628_alu.sv
// Combinational datapath for the up0628: computes the new
// accumulator and carry plus which of them the opcode writes.
module up0628_alu
    import up0628_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] operand,
    input  logic [3:0] opcode,
    input  logic       shift_right,
    input  logic       c_in,
    output logic [7:0] result,
    output logic       carry_out,
    output logic       writes_a,
    output logic       writes_c
);

    always_comb begin
        result    = a;
        carry_out = c_in;
        writes_a  = 1'b0;
        writes_c  = 1'b0;
        unique case (opcode)
            OP_LDI, OP_MOVA, OP_IN: begin
                result   = operand;
                writes_a = 1'b1;
            end
            OP_LDH: begin
                result   = {operand[3:0], a[3:0]};
                writes_a = 1'b1;
            end
            OP_ADD: begin
                {carry_out, result} = {1'b0, a} + {1'b0, operand};
                writes_a = 1'b1;
                writes_c = 1'b1;
            end
            // bit 8 of the 9-bit difference is the borrow
            OP_SUB: begin
                {carry_out, result} = {1'b0, a} - {1'b0, operand};
                writes_a = 1'b1;
                writes_c = 1'b1;
            end
            OP_AND: begin
                result   = a & operand;
                writes_a = 1'b1;
            end
            OP_OR: begin
                result   = a | operand;
                writes_a = 1'b1;
            end
            OP_XOR: begin
                result   = a ^ operand;
                writes_a = 1'b1;
            end
            OP_SH: begin
                if (shift_right) begin
                    carry_out = a[0];
                    result    = {1'b0, a[7:1]};
                end else begin
                    carry_out = a[7];
                    result    = {a[6:0], 1'b0};
                end
                writes_a = 1'b1;
                writes_c = 1'b1;
            end
            default: begin
                result = a;
            end
        endcase
    end

endmodule

// File: rtl/up0628_core.sv
// up0628 8-bit accumulator micro with serially loaded 16x8 RAM.
// Optional UP0628_ACC_VIEW_EN: uio_in[2] shows A on uo_out.
module up0628_core
    import up0628_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    up0628_if.slave  bus
);

    logic [7:0] ram [16];
    logic [7:0] rf  [4];
    logic [3:0] pc;
    logic [3:0] load_addr;
    logic [7:0] acc;
    logic [7:0] out_reg;
    logic       z;
    logic       c;

    logic       load;
    logic       hold;
    logic       step;
    logic [7:0] instr;
    logic [3:0] op;
    logic [3:0] k;
    logic [1:0] ridx;
    logic [7:0] operand;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       wr_a;
    logic       wr_c;
    logic       take_jump;
    logic [3:0] pc_next;

    assign load  = bus.uio_in[LOAD_BIT];
    assign hold  = bus.uio_in[HOLD_BIT];
    assign step  = bus.ena & ~hold;
    assign instr = ram[pc];
    assign op    = instr[7:4];
    assign k     = instr[3:0];
    assign ridx  = instr[1:0];

    always_comb begin
        operand = rf[ridx];
        if (op == OP_LDI || op == OP_LDH)
            operand = {4'h0, k};
        else if (op == OP_IN)
            operand = bus.ui_in;
    end

    up0628_alu u_alu (
        .a           (acc),
        .operand     (operand),
        .opcode      (op),
        .shift_right (instr[0]),
        .c_in        (c),
        .result      (alu_res),
        .carry_out   (alu_c),
        .writes_a    (wr_a),
        .writes_c    (wr_c)
    );

    always_comb begin
        unique case (op)
            OP_JMP:  take_jump = 1'b1;
            OP_JZ:   take_jump = z;
            OP_JC:   take_jump = c;
            default: take_jump = 1'b0;
        endcase
    end

    assign pc_next = take_jump ? k : pc + 4'd1;

    // program RAM has no reset so a reset restarts the loaded program
    always_ff @(posedge clk) begin
        if (rst_n && step && load)
            ram[load_addr] <= bus.ui_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            load_addr <= '0;
            acc       <= '0;
            out_reg   <= '0;
            z         <= 1'b0;
            c         <= 1'b0;
            for (int i = 0; i < 4; i++)
                rf[i] <= '0;
        end else if (step) begin
            if (load) begin
                load_addr <= load_addr + 4'd1;
                pc        <= '0;
            end else begin
                load_addr <= '0;
                pc        <= pc_next;
                if (wr_a) begin
                    acc <= alu_res;
                    z   <= (alu_res == 8'h00);
                end
                if (wr_c)
                    c <= alu_c;
                if (op == OP_MOVR)
                    rf[ridx] <= acc;
                if (op == OP_OUT)
                    out_reg <= acc;
            end
        end
    end

`ifdef UP0628_ACC_VIEW_EN
    assign bus.uo_out = bus.uio_in[VIEW_BIT] ? acc : out_reg;
`else
    assign bus.uo_out = out_reg;
`endif

    assign bus.uio_out = {pc, c, 3'b000};
    assign bus.uio_oe  = UIO_OE_VAL;

    wire unused_uio = &{1'b0, bus.uio_in[7:2]};

endmodule

// File: tb/tb_up0628_core.sv
// Self-checking bench for up0628_core: loads small programs
// and checks port results through an expectation queue.
module tb_up0628_core;

    logic clk;
    logic rst_n;

    up0628_if bus ();

    up0628_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input string t, input logic [7:0] v);
        exp_t x;
        x.tag = t;
        x.val = v;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [127:0] img, input int n);
        bus.uio_in[0] = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.ui_in = img[8*(n-1-i) +: 8];
            tick();
        end
        bus.uio_in[0] = 1'b0;
    endtask

    task automatic test_reset();
        push("rst_uo_out", 8'h00);
        push("rst_uio_out", 8'h00);
        push("rst_uio_oe", 8'hF8);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.uio_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uio_out, e.val);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.uio_oe !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uio_oe, e.val);
            n_fail++;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_add();
        load_prog({8'h15, 8'h30, 8'h13, 8'h50, 8'hC0, 8'hD5}, 6);
        push("add_out", 8'h08);
        push("add_pc_c", {4'h5, 1'b0, 3'b000});
        repeat (5) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        repeat (3) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uio_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uio_out, e.val);
            n_fail++;
        end
    endtask

    task automatic test_borrow();
        load_prog({8'h13, 8'h31, 8'h12, 8'h61, 8'hC0, 8'hD5}, 6);
        push("sub_out", 8'hFF);
        push("sub_pc_c", {4'h5, 1'b1, 3'b000});
        repeat (6) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.uio_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uio_out, e.val);
            n_fail++;
        end
    endtask

    task automatic test_in();
        logic [7:0] pat [2];
        pat[0] = 8'hA5;
        pat[1] = 8'h3C;
        load_prog({8'hB0, 8'hC0, 8'hD0}, 3);
        for (int p = 0; p < 2; p++) begin
            bit seen;
            bus.ui_in = pat[p];
            push("in_follow", pat[p]);
            e = sb.pop_front();
            seen = 1'b0;
            for (int t = 0; t < 3 && !seen; t++) begin
                tick();
                if (bus.uo_out === e.val)
                    seen = 1'b1;
            end
            n_checks++;
            if (!seen) begin
                $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
                n_fail++;
            end
        end
    endtask

    task automatic test_branch();
        bit saw_f;
        load_prog({8'h10, 8'hE4, 8'h1F, 8'hC0,
                   8'h17, 8'hC0, 8'hD6}, 7);
        push("br_never_0f", 8'h00);
        push("br_out", 8'h07);
        saw_f = 1'b0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (bus.uo_out === 8'h0F)
                saw_f = 1'b1;
        end
        e = sb.pop_front();
        n_checks++;
        if ({7'd0, saw_f} !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, saw_f, e.val);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
    endtask

    task automatic test_logic();
        load_prog({8'h1C, 8'h2A, 8'h32, 8'h1F,
                   8'h72, 8'hC0, 8'hD6}, 7);
        push("and_out", 8'h0C);
        repeat (8) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        load_prog({8'h1C, 8'h2A, 8'h32, 8'h13,
                   8'h82, 8'h92, 8'hC0, 8'hD7}, 8);
        push("or_xor_out", 8'h03);
        repeat (9) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        load_prog({8'h17, 8'h31, 8'h10, 8'h41,
                   8'hC0, 8'hD5}, 6);
        push("mov_out", 8'h07);
        repeat (7) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
    endtask

    task automatic test_shift_jc();
        load_prog({8'h11, 8'h2C, 8'hA0, 8'hF5,
                   8'h1F, 8'hA1, 8'hC0, 8'hD7}, 8);
        push("shift_out", 8'h41);
        push("shift_pc_c", {4'h7, 1'b0, 3'b000});
        repeat (9) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.uio_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uio_out, e.val);
            n_fail++;
        end
    endtask

    task automatic test_view();
        load_prog({8'h1A, 8'hC0, 8'h13, 8'hD3}, 4);
        push("view_off", 8'h0A);
`ifdef UP0628_ACC_VIEW_EN
        push("view_on", 8'h03);
`else
        push("view_on", 8'h0A);
`endif
        repeat (5) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        bus.uio_in[2] = 1'b1;
        #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        bus.uio_in[2] = 1'b0;
    endtask

    task automatic test_hold_reset();
        int bad;
        load_prog({8'hB0, 8'hC0, 8'hD0}, 3);
        bus.ui_in = 8'hA5;
        push("hold_pre_out", 8'hA5);
        push("hold_pre_pc", {4'h2, 4'h0});
        repeat (2) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if ({bus.uio_out[7:4], 4'h0} !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uio_out, e.val);
            n_fail++;
        end
        bus.uio_in[1] = 1'b1;
        bus.uio_in[0] = 1'b1;
        bus.ui_in = 8'h11;
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (bus.uio_out[7:4] !== 4'h2 || bus.uo_out !== 8'hA5)
                bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL hold_freeze got %0d bad cycles exp 0", bad);
            n_fail++;
        end
        bus.uio_in[0] = 1'b0;
        bus.uio_in[1] = 1'b0;
        bus.ena = 1'b0;
        bad = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (bus.uio_out[7:4] !== 4'h2)
                bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            $display("FAIL ena_freeze got %0d bad cycles exp 0", bad);
            n_fail++;
        end
        bus.ena = 1'b1;
        repeat (2) tick();
        push("midrun_rst_out", 8'h00);
        push("midrun_rst_pc", 8'h00);
        rst_n = 1'b0;
        #1;
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
        e = sb.pop_front();
        n_checks++;
        if (bus.uio_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uio_out, e.val);
            n_fail++;
        end
        bus.ui_in = 8'hA5;
        tick();
        rst_n = 1'b1;
        push("rerun_out", 8'hA5);
        repeat (2) tick();
        e = sb.pop_front();
        n_checks++;
        if (bus.uo_out !== e.val) begin
            $display("FAIL %s got %h exp %h", e.tag, bus.uo_out, e.val);
            n_fail++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b1;
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        test_reset();
        test_add();
        test_borrow();
        test_in();
        test_branch();
        test_logic();
        test_shift_jc();
        test_view();
        test_hold_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
